// File: rtl/csi2_line_reader.sv
// Ping-pong line-buffer reader: packs bank bytes LE into 32-bit words; optional LINE_CRC_EN adds line_crc.
// First word valid 4 cycles after rd_addr=0, one word per 4 cycles; holds rd_addr/pack when m_ready stalls a transfer.
module csi2_line_reader #(
    parameter int ADDR_W  = 16,
    parameter int MAX_LEN = 65
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_done,
    input  logic              line_bank,
    input  logic [ADDR_W-1:0] line_len,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bank,
    input  logic [7:0]        rd_data,
    output logic [31:0]       m_data,
    output logic [3:0]        m_keep,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
`ifdef LINE_CRC_EN
    output logic [15:0]       line_crc,
`endif
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] MAX_LEN_A = ADDR_W'(MAX_LEN);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] pend_len;
    logic              pend_vld;
    logic              pend_bank;
    logic [ADDR_W-1:0] req_len;
    logic [ADDR_W-1:0] start_len;
    logic              start_bank;
    logic [31:0]       pack_q;
    logic [31:0]       word;
    logic [3:0]        keep;
    logic [1:0]        lane;
    logic              new_req, last_byte, need_xfer, stall, capture;
    logic              hs, last_hs, free, start, direct, store, drop;

    assign req_len    = (line_len > MAX_LEN_A) ? MAX_LEN_A : line_len;
    assign new_req    = line_done && (line_len != '0);
    assign lane       = rd_addr[1:0];
    assign last_byte  = (rd_addr == len_q - ADDR_W'(1));
    assign need_xfer  = (lane == 2'd3) || last_byte;
    assign stall      = need_xfer && m_valid && !m_ready;
    assign capture    = (state_q == READ) && !stall;
    assign hs         = m_valid && m_ready;
    assign last_hs    = hs && m_last && (state_q == DRAIN);

    // A new line may start from IDLE or directly at the m_last handshake, so busy never dips between queued lines.
    assign free       = (state_q == IDLE) || last_hs;
    assign start      = free && (pend_vld || new_req);
    assign direct     = free && !pend_vld && new_req;
    assign start_bank = pend_vld ? pend_bank : line_bank;
    assign start_len  = pend_vld ? pend_len : req_len;
    assign store      = new_req && !direct && (!pend_vld || start);
    assign drop       = new_req && !direct && pend_vld && !start;
    assign busy       = (state_q != IDLE);

    always_comb begin
        word = pack_q;
        word[{lane, 3'b000} +: 8] = rd_data;
        case (lane)
            2'd0:    keep = 4'h1;
            2'd1:    keep = 4'h3;
            2'd2:    keep = 4'h7;
            default: keep = 4'hF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (capture && last_byte) state_d = DRAIN;
            DRAIN:   if (last_hs) state_d = start ? READ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_addr   <= '0;
            rd_bank   <= 1'b0;
            len_q     <= '0;
            pack_q    <= '0;
            m_data    <= '0;
            m_keep    <= '0;
            m_last    <= 1'b0;
            m_valid   <= 1'b0;
            pend_vld  <= 1'b0;
            pend_bank <= 1'b0;
            pend_len  <= '0;
            overflow  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (start) begin
                rd_addr <= '0;
                rd_bank <= start_bank;
                len_q   <= start_len;
                pack_q  <= '0;
            end else if (capture) begin
                rd_addr <= rd_addr + ADDR_W'(1);
                pack_q  <= need_xfer ? '0 : word;
            end

            // Load and handshake may coincide; the load wins so words stream back-to-back.
            if (capture && need_xfer) begin
                m_data  <= word;
                m_keep  <= keep;
                m_last  <= last_byte;
                m_valid <= 1'b1;
            end else if (hs) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end

            pend_vld <= (pend_vld && !start) || store;
            if (store) begin
                pend_bank <= line_bank;
                pend_len  <= req_len;
            end
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef LINE_CRC_EN
    logic [15:0] crc_q;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q    <= 16'hFFFF;
            line_crc <= 16'hFFFF;
        end else begin
            if (start)        crc_q <= 16'hFFFF;
            else if (capture) crc_q <= crc_byte(crc_q, rd_data);
            if (last_hs) line_crc <= crc_q;
        end
    end
`endif

endmodule

// File: tb/tb_csi2_line_reader.sv
// Randomised and directed bench for csi2_line_reader against a line-level word/queue model.
`timescale 1ns/1ps
module tb_csi2_line_reader;
    localparam int ADDR_W  = 16;
    localparam int MAX_LEN = 65;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              line_done = 1'b0;
    logic              line_bank = 1'b0;
    logic [ADDR_W-1:0] line_len = '0;
    logic              m_ready = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_bank;
    logic [7:0]        rd_data;
    logic [31:0]       m_data;
    logic [3:0]        m_keep;
    logic              m_last, m_valid, busy, overflow;
`ifdef LINE_CRC_EN
    logic [15:0]       line_crc;
`endif

    int checks = 0;
    int errs   = 0;

    logic [7:0] mem [2][128];

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [15:0] crc;
    } word_t;

    word_t       exp_q[$];
    word_t       got_q[$];
    int          in_flight = 0;
    logic        mdl_ovf = 1'b0;
    logic [15:0] mdl_crc = 16'hFFFF;

    always #5 clk = ~clk;

    assign rd_data = (rd_addr < 16'd128) ? mem[rd_bank][rd_addr[6:0]] : 8'h00;

    csi2_line_reader #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset(reset),
        .line_done(line_done), .line_bank(line_bank), .line_len(line_len),
        .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_data(rd_data),
        .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy),
`ifdef LINE_CRC_EN
        .line_crc(line_crc),
`endif
        .overflow(overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    // Expand an accepted line into the words it must produce.
    task automatic push_line(input logic bank, input int len);
        int          n;
        word_t       w;
        logic [15:0] c;
        n = (len > MAX_LEN) ? MAX_LEN : len;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) c = crc_upd(c, mem[bank][i]);
        for (int base = 0; base < n; base += 4) begin
            w = '0;
            for (int b = 0; b < 4; b++) begin
                if (base + b < n) begin
                    w.data[8*b +: 8] = mem[bank][base+b];
                    w.keep[b] = 1'b1;
                end
            end
            w.last = (base + 4 >= n);
            w.crc  = c;
            exp_q.push_back(w);
        end
    endtask

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;

    always @(negedge clk) begin
        int    eff;
        word_t e, g;
        if (reset) begin
            exp_q.delete();
            in_flight  = 0;
            mdl_ovf    = 1'b0;
            mdl_crc    = 16'hFFFF;
            prev_stall = 1'b0;
        end else begin
            chk("busy", busy, in_flight > 0);
            chk("overflow", overflow, mdl_ovf);
`ifdef LINE_CRC_EN
            chk("line_crc", line_crc, mdl_crc);
`endif
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
                chk("stall_keep", m_keep, prev_keep);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_keep  = m_keep;
            eff = in_flight;
            if (m_valid && m_ready) begin
                g = '0;
                g.data = m_data;
                g.keep = m_keep;
                g.last = m_last;
                got_q.push_back(g);
                chk("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e.data);
                    chk("m_keep", m_keep, e.keep);
                    chk("m_last", m_last, e.last);
                    if (e.last) begin
                        in_flight--;
                        eff = in_flight;
                        mdl_crc = e.crc;
                    end
                end
            end
            // At most one line reading plus one queued; a slot freed at this edge can be refilled.
            if (line_done && line_len != '0) begin
                if (eff < 2) begin
                    push_line(line_bank, int'(line_len));
                    in_flight++;
                end else begin
                    mdl_ovf = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic bank, input int len);
        line_done = 1'b1;
        line_bank = bank;
        line_len  = ADDR_W'(len);
        tick();
        line_done = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || in_flight != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", n < budget, 1);
    endtask

    task automatic chk_word(input string name, input int idx, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
        chk({name, "_present"}, got_q.size() > idx, 1);
        if (got_q.size() > idx) begin
            chk({name, "_data"}, got_q[idx].data, d);
            chk({name, "_keep"}, got_q[idx].keep, k);
            chk({name, "_last"}, got_q[idx].last, l);
        end
    endtask

    initial begin
        int          n;
        logic [31:0] snap_d;
        logic [3:0]  snap_k;
        logic [15:0] snap_a;

        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 128; i++) mem[b][i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[0][i] = 8'(i + 1);
        for (int i = 0; i < 4; i++) mem[1][i] = 8'(8'hA0 + i);

        m_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_bank", rd_bank, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_keep", m_keep, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
`ifdef LINE_CRC_EN
        chk("rst_line_crc", line_crc, 16'hFFFF);
`endif

        // 8-byte line with latency
        got_q.delete();
        req(1'b0, 8);
        chk("start_addr", rd_addr, 0);
        chk("start_bank", rd_bank, 0);
        chk("start_busy", busy, 1);
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        chk("first_valid_latency", n, 4);
        wait_idle(100);
        chk("len8_words", got_q.size(), 2);
        chk_word("len8_w0", 0, 32'h04030201, 4'hF, 1'b0);
        chk_word("len8_w1", 1, 32'h08070605, 4'hF, 1'b1);
        chk("len8_busy_end", busy, 0);

        // 5-byte line, partial final word
        got_q.delete();
        req(1'b0, 5);
        wait_idle(100);
        chk_word("len5_w0", 0, 32'h04030201, 4'hF, 1'b0);
        chk_word("len5_w1", 1, 32'h00000005, 4'h1, 1'b1);

        // backpressure
        got_q.delete();
        m_ready = 1'b0;
        req(1'b0, 8);
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        chk("stall_valid_seen", m_valid, 1);
        repeat (3) tick();
        chk("stall_addr_hold", rd_addr, 7);
        snap_d = m_data;
        snap_k = m_keep;
        snap_a = rd_addr;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_m_data", m_data, snap_d);
            chk("stall_m_keep", m_keep, snap_k);
            chk("stall_rd_addr", rd_addr, snap_a);
        end
        m_ready = 1'b1;
        wait_idle(100);
        chk("stall_words", got_q.size(), 2);
        chk_word("stall_w0", 0, 32'h04030201, 4'hF, 1'b0);
        chk_word("stall_w1", 1, 32'h08070605, 4'hF, 1'b1);

        // pending slot and overflow
        got_q.delete();
        req(1'b0, 8);
        req(1'b1, 4);
        req(1'b0, 3);
        chk("ovf_set", overflow, 1);
        n = 0;
        while (!(m_valid && m_ready && m_last) && n < 50) begin
            tick();
            n++;
        end
        chk("pend_first_last_seen", n < 50, 1);
        tick();
        chk("pend_next_bank", rd_bank, 1);
        chk("pend_next_addr", rd_addr, 0);
        chk("pend_next_busy", busy, 1);
        wait_idle(100);
        chk("pend_words", got_q.size(), 3);
        chk_word("pend_w2", 2, 32'hA3A2A1A0, 4'hF, 1'b1);
        chk("ovf_sticky", overflow, 1);

        // reset mid-line
        req(1'b0, 8);
        n = 0;
        while (rd_addr != 16'd5 && n < 20) begin
            tick();
            n++;
        end
        chk("rst_mid_reached", rd_addr, 5);
        reset = 1'b1;
        tick();
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ovf", overflow, 0);
        chk("rst_mid_addr", rd_addr, 0);
        reset = 1'b0;
        got_q.delete();
        req(1'b0, 8);
        wait_idle(100);
        chk_word("after_rst_w0", 0, 32'h04030201, 4'hF, 1'b0);
        chk_word("after_rst_w1", 1, 32'h08070605, 4'hF, 1'b1);

        // zero length ignored
        req(1'b0, 0);
        tick();
        chk("len0_busy", busy, 0);
        chk("len0_ovf", overflow, 0);

        // clamp to MAX_LEN
        for (int i = 0; i < 128; i++) mem[1][i] = 8'($urandom_range(0, 255));
        got_q.delete();
        req(1'b1, 200);
        wait_idle(300);
        chk("clamp_words", got_q.size(), 17);
        if (got_q.size() == 17) chk("clamp_last_keep", got_q[16].keep, 4'h1);

`ifdef LINE_CRC_EN
        mem[0][0] = 8'h00;
        got_q.delete();
        req(1'b0, 1);
        wait_idle(100);
        chk_word("crc_w0", 0, 32'h00000000, 4'h1, 1'b1);
        chk("crc_single_zero", line_crc, 16'h0F87);
`endif

        // randomised traffic
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 128; i++) mem[b][i] = 8'($urandom_range(0, 255));
        for (int c = 0; c < 3000; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                line_done = 1'b1;
                line_bank = 1'($urandom_range(0, 1));
                n = $urandom_range(0, 9);
                if (n == 0)      line_len = '0;
                else if (n == 1) line_len = ADDR_W'($urandom_range(66, 300));
                else             line_len = ADDR_W'($urandom_range(1, 70));
            end else begin
                line_done = 1'b0;
            end
            tick();
        end
        line_done = 1'b0;
        m_ready = 1'b1;
        wait_idle(2000);
        chk("rand_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/csi2_line_reader.md
Name: csi2_line_reader

Overview:
- Read side of the ping-pong CSI-2 line buffer.
- When the byte writer reports a completed line in one bank, this block reads that bank back one byte per cycle and packs the bytes little-endian into 32-bit words.
- Words stream out on a valid/ready interface to the downstream pixel pipe.
- It queues one pending line so the writer can fill the other bank while a read is in progress.

Parameters:
- ADDR_W, 16, width of the line-buffer byte address and of line_len.
- MAX_LEN, 65, line-buffer depth in bytes; larger line_len values are clamped to this.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- line_done  input  1  single-cycle pulse: line_len bytes are complete in bank line_bank.
- line_bank  input  1  bank (0/1) holding the completed line; sampled with line_done.
- line_len  input  ADDR_W  byte count of the completed line; sampled with line_done.
- rd_addr  output  ADDR_W  line-buffer read address.
- rd_bank  output  1  line-buffer bank select.
- rd_data  input  8  buffer read data; combinational from rd_addr/rd_bank in the same cycle.
- m_data  output  32  packed word; byte k of the word is in bits [8k+7:8k].
- m_keep  output  4  valid-byte mask for m_data.
- m_last  output  1  final word of the line.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts the word.
- busy  output  1  a line is being read or is still draining.
- overflow  output  1  sticky flag: a line_done request was dropped.

Behaviour:
- Reset values: rd_addr=0, rd_bank=0, m_data=0, m_keep=0, m_last=0, m_valid=0, busy=0, overflow=0. Pending slot empty, FSM in IDLE.
- Reset asserted mid-line aborts the read. All outputs take their reset values at that edge; no partial word is emitted.
- FSM states:
  - IDLE: line_done with line_len!=0, or a valid pending slot, moves to READ. Latch bank and effective length L = min(line_len, MAX_LEN). Set rd_addr=0 and busy=1.
  - READ: each cycle the pack stage is not stalled, capture rd_data into lane (rd_addr mod 4) and increment rd_addr.
    - On the 4th lane, or on byte L-1, transfer the pack register to the output register (m_valid=1) at the same edge.
    - m_keep = mask of filled lanes; unused lanes of m_data are 0. m_last=1 for the word containing byte L-1.
    - After byte L-1, go to DRAIN.
  - DRAIN: wait for the m_last handshake (m_valid && m_ready). Then take the pending slot if valid (back to READ next cycle), else go to IDLE and clear busy.
- Stall: a transfer is needed while m_valid=1 and m_ready=0. In that case rd_addr and the pack register hold, and m_data/m_keep/m_last stay stable.
- m_valid stays high until handshake. Handshake and a new load at the same edge are allowed, giving back-to-back words.
- Latency from an IDLE line_done at cycle T:
  - rd_addr=0 is driven in cycle T+1.
  - The first full word has m_valid=1 in cycle T+5.
  - Steady rate is one word per 4 cycles.
- Pending slot, depth 1:
  - line_done while busy and the slot is empty: store bank and length.
  - line_done while the slot is full: drop the request and set overflow=1, which stays set until reset.
  - line_done at the same edge the slot is consumed: the new request is stored.
- line_len=0 is ignored: no state change and no overflow.
- rd_bank is constant for the duration of a line.

Optional Feature:
- Macro LINE_CRC_EN.
- When defined:
  - Adds output line_crc[15:0].
  - Computes the CSI-2 CRC over the L bytes: reflected polynomial 0x8408, seed 0xFFFF, LSB first, no final XOR.
  - The CRC is reseeded on each line start. line_crc is updated at the m_last handshake and held until the next m_last handshake.
  - Reset value of line_crc is 0xFFFF.
- When undefined: the port and the CRC logic are absent; all other behaviour is identical.

Test Plan:
- Bank 0 holds 0x01..0x08, line_done with line_len=8, m_ready=1 -> word 0x04030201 with keep 0xF and last=0, then 0x08070605 with keep 0xF and last=1; first m_valid 4 cycles after rd_addr=0; busy falls after the last handshake.
- line_len=5, bytes 0x01..0x05 -> 0x04030201 with keep 0xF, then 0x00000005 with keep 0x1 and last=1.
- m_ready held low for 10 cycles while a word is valid -> m_data, m_keep and rd_addr stable throughout; the stream resumes in order with no lost or duplicated byte.
- line_done (bank 0, len 8), then bank 1 len 4 while busy, then a third line_done while the slot is full -> overflow=1; bank 1 is read immediately after the bank-0 m_last handshake; the third request is never read.
- Reset asserted during the second word of an 8-byte line -> next cycle m_valid=0, busy=0, overflow=0; a fresh line_done then reads correctly from rd_addr=0.
- LINE_CRC_EN defined, single byte 0x00 with line_len=1 -> m_data=0x00000000, keep 0x1, last=1, line_crc=0x0F87 after the handshake.
